// File: rtl/watch_dp_gen_pkg.sv
// rtl/watch_dp_gen_pkg.sv - shared field encodings, field limits and 24h->12h display helper
package watch_pkg;

    typedef enum logic [1:0] {
        FLD_SEC  = 2'd0,
        FLD_MIN  = 2'd1,
        FLD_HOUR = 2'd2,
        FLD_NONE = 2'd3
    } field_sel_e;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    // Internal hours 0 and 12 both show as 12; afternoon hours fold down by 12.
    function automatic logic [4:0] hour_24_to_12(input logic [4:0] hour);
        if (hour == 5'd0) begin
            return 5'd12;
        end else if (hour > 5'd12) begin
            return hour - 5'd12;
        end else begin
            return hour;
        end
    endfunction

endpackage

// File: rtl/watch_dp_gen_if.sv
// rtl/watch_dp_gen_if.sv - control/display bundle of the watch datapath; alarm signals under ALARM_EN
interface watch_dp_gen_if #(
    parameter int SUB_W = 7
);
    logic             i_run;
    logic [1:0]       i_field_sel;
    logic             i_up;
    logic             i_down;
    logic             i_clr_sub;
    logic             i_mode_12h;
    logic [SUB_W-1:0] o_sub;
    logic [5:0]       o_sec;
    logic [5:0]       o_min;
    logic [4:0]       o_hour;
    logic             o_pm;
    logic             o_sec_pulse;
`ifdef ALARM_EN
    logic             i_alarm_set;
    logic             i_alarm_on;
    logic             o_alarm;
`endif

    modport master (
        output i_run, i_field_sel, i_up, i_down, i_clr_sub, i_mode_12h,
`ifdef ALARM_EN
        output i_alarm_set, i_alarm_on,
        input  o_alarm,
`endif
        input  o_sub, o_sec, o_min, o_hour, o_pm, o_sec_pulse
    );

    modport slave (
        input  i_run, i_field_sel, i_up, i_down, i_clr_sub, i_mode_12h,
`ifdef ALARM_EN
        input  i_alarm_set, i_alarm_on,
        output o_alarm,
`endif
        output o_sub, o_sec, o_min, o_hour, o_pm, o_sec_pulse
    );

endinterface

// File: rtl/watch_dp_gen_wrap_counter.sv
// rtl/watch_dp_gen_wrap_counter.sv - 0..MAX up/down counter with wrap and combinational carry out
module wdp_wrap_counter #(
    parameter int unsigned MAX     = 59,
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic             wrap_next
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_value <= RST_V;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc && !dec) begin
            r_value <= (r_value == MAX_V) ? '0 : r_value + WIDTH'(1);
        end else if (dec && !inc) begin
            r_value <= (r_value == '0) ? MAX_V : r_value - WIDTH'(1);
        end
    end

    // Carry must be seen by the next field in the same cycle so the whole chain lands on one edge.
    assign wrap_next = inc && !dec && (r_value == MAX_V);
    assign value     = r_value;

endmodule

// File: rtl/watch_dp_gen.sv
// rtl/watch_dp_gen.sv - tick divider and sub/sec/min/hour time-of-day datapath; ALARM_EN adds a minute alarm
module watch_dp_gen
    import watch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100,
    parameter int SUB_W       = 7,
    parameter int HOUR_RST    = 12,
    parameter int MIN_RST     = 0
) (
    input  logic           clk,
    input  logic           rst,
    watch_dp_gen_if.slave  io_wdp
);

    localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_pend;
    logic             r_sec_pulse;

    logic             w_tick;
    logic             w_adj;
    logic             w_adj_up;
    logic             w_adj_dn;
    logic             w_tick_src;
    logic             w_tick_apply;
    logic [SUB_W-1:0] w_sub;
    logic [5:0]       w_sec;
    logic [5:0]       w_min;
    logic [4:0]       w_hour;
    logic             w_sub_wrap;
    logic             w_sec_wrap;
    logic             w_min_wrap;
    logic             w_hour_wrap_unused;

    assign w_tick   = (r_div == DIV_LAST);
    assign w_adj    = (io_wdp.i_up ^ io_wdp.i_down) && (io_wdp.i_field_sel != FLD_NONE);
    assign w_adj_up = w_adj & io_wdp.i_up;
    assign w_adj_dn = w_adj & io_wdp.i_down;

    // An adjust wins the cycle; the tick it collides with is parked in r_pend for the next one.
    assign w_tick_src   = (w_tick | r_pend) & io_wdp.i_run & ~io_wdp.i_clr_sub;
    assign w_tick_apply = w_tick_src & ~w_adj;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div       <= '0;
            r_pend      <= 1'b0;
            r_sec_pulse <= 1'b0;
        end else begin
            r_div       <= (io_wdp.i_clr_sub || w_tick) ? '0 : r_div + DIV_W'(1);
            r_pend      <= w_tick_src & w_adj;
            r_sec_pulse <= w_sub_wrap;
        end
    end

    wdp_wrap_counter #(.MAX(TICK_HZ - 1), .WIDTH(SUB_W), .RST_VAL(0)) u_sub (
        .clk(clk), .rst(rst), .clr(io_wdp.i_clr_sub),
        .inc(w_tick_apply), .dec(1'b0),
        .value(w_sub), .wrap_next(w_sub_wrap)
    );

    // w_sub_wrap implies no adjust this cycle, so gating with it keeps adjust wraps from carrying.
    wdp_wrap_counter #(.MAX(SEC_MAX), .WIDTH(6), .RST_VAL(0)) u_sec (
        .clk(clk), .rst(rst), .clr(1'b0),
        .inc(w_sub_wrap | (w_adj_up && io_wdp.i_field_sel == FLD_SEC)),
        .dec(w_adj_dn && io_wdp.i_field_sel == FLD_SEC),
        .value(w_sec), .wrap_next(w_sec_wrap)
    );

    wdp_wrap_counter #(.MAX(MIN_MAX), .WIDTH(6), .RST_VAL(MIN_RST)) u_min (
        .clk(clk), .rst(rst), .clr(1'b0),
        .inc((w_sub_wrap & w_sec_wrap) | (w_adj_up && io_wdp.i_field_sel == FLD_MIN)),
        .dec(w_adj_dn && io_wdp.i_field_sel == FLD_MIN),
        .value(w_min), .wrap_next(w_min_wrap)
    );

    wdp_wrap_counter #(.MAX(HOUR_MAX), .WIDTH(5), .RST_VAL(HOUR_RST)) u_hour (
        .clk(clk), .rst(rst), .clr(1'b0),
        .inc((w_sub_wrap & w_sec_wrap & w_min_wrap) | (w_adj_up && io_wdp.i_field_sel == FLD_HOUR)),
        .dec(w_adj_dn && io_wdp.i_field_sel == FLD_HOUR),
        .value(w_hour), .wrap_next(w_hour_wrap_unused)
    );

    assign io_wdp.o_sub       = w_sub;
    assign io_wdp.o_sec       = w_sec;
    assign io_wdp.o_min       = w_min;
    assign io_wdp.o_hour      = io_wdp.i_mode_12h ? hour_24_to_12(w_hour) : w_hour;
    assign io_wdp.o_pm        = (w_hour >= 5'd12);
    assign io_wdp.o_sec_pulse = r_sec_pulse;

`ifdef ALARM_EN
    logic [4:0] r_alarm_hour;
    logic [5:0] r_alarm_min;
    logic       r_alarm;
    logic [5:0] w_min_after;
    logic [4:0] w_hour_after;

    // Match against the hour:min that the second wrap is about to produce, so the alarm fires at hh:mm:00.
    assign w_min_after  = w_min_wrap ? 6'd0 : w_min + 6'd1;
    assign w_hour_after = !w_min_wrap ? w_hour :
                          (w_hour == 5'(HOUR_MAX)) ? 5'd0 : w_hour + 5'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_alarm_hour <= '0;
            r_alarm_min  <= '0;
            r_alarm      <= 1'b0;
        end else begin
            if (io_wdp.i_alarm_set) begin
                r_alarm_hour <= w_hour;
                r_alarm_min  <= w_min;
            end
            r_alarm <= w_sub_wrap & w_sec_wrap & io_wdp.i_alarm_on &
                       (w_hour_after == r_alarm_hour) & (w_min_after == r_alarm_min);
        end
    end

    assign io_wdp.o_alarm = r_alarm;
`endif

endmodule

// File: tb/tb_watch_dp_gen.sv
// tb/tb_watch_dp_gen.sv - randomized and directed bench for watch_dp_gen against a time-in-ticks model
module tb_watch_dp_gen;

    localparam int CLK_HZ = 1000;
    localparam int TICK   = 10;
    localparam int SUBW   = 4;
    localparam int DIV    = CLK_HZ / TICK;
    localparam int DAY    = 24 * 3600 * TICK;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic run = 1'b1;
    logic [1:0] sel = 2'd3;
    logic up = 1'b0;
    logic down = 1'b0;
    logic clr = 1'b0;
    logic mode12 = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    int m_t;
    int m_phase;
    bit m_pend;
    bit m_pulse;

    always #5 clk = ~clk;

    watch_dp_gen_if #(.SUB_W(SUBW)) wif ();

    assign wif.i_run       = run;
    assign wif.i_field_sel = sel;
    assign wif.i_up        = up;
    assign wif.i_down      = down;
    assign wif.i_clr_sub   = clr;
    assign wif.i_mode_12h  = mode12;
`ifdef ALARM_EN
    assign wif.i_alarm_set = 1'b0;
    assign wif.i_alarm_on  = 1'b0;
`endif

    watch_dp_gen #(
        .CLK_FREQ_HZ(CLK_HZ), .TICK_HZ(TICK), .SUB_W(SUBW), .HOUR_RST(12), .MIN_RST(0)
    ) dut (
        .clk(clk), .rst(rst), .io_wdp(wif.slave)
    );

    function automatic int m_sub();  return m_t % TICK; endfunction
    function automatic int m_sec();  return (m_t / TICK) % 60; endfunction
    function automatic int m_min();  return (m_t / (TICK * 60)) % 60; endfunction
    function automatic int m_hour(); return m_t / (TICK * 3600); endfunction

    function automatic int m_field(input int s);
        case (s)
            0:       return m_sec();
            1:       return m_min();
            default: return m_hour();
        endcase
    endfunction

    function automatic int disp_hour(input int h, input bit m12);
        if (!m12) return h;
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit tick, go, adj;
        int s, mi, h, sb, d;
        if (!rst) begin
            m_phase = 0;
            m_t     = 12 * 3600 * TICK;
            m_pend  = 0;
            m_pulse = 0;
        end else begin
            tick    = (m_phase == DIV - 1);
            m_phase = clr ? 0 : (m_phase + 1) % DIV;
            go      = (tick || m_pend) && run && !clr;
            adj     = (up != down) && (sel != 2'd3);
            if (adj) begin
                s = m_sec(); mi = m_min(); h = m_hour(); sb = m_sub();
                d = up ? 1 : -1;
                case (sel)
                    2'd0:    s  = (s + d + 60) % 60;
                    2'd1:    mi = (mi + d + 60) % 60;
                    default: h  = (h + d + 24) % 24;
                endcase
                m_t = ((h * 60 + mi) * 60 + s) * TICK + sb;
            end
            m_pend  = go && adj;
            m_pulse = 0;
            if (go && !adj) begin
                m_t     = (m_t + 1) % DAY;
                m_pulse = (m_t % TICK == 0);
            end
            if (clr) m_t = m_t - (m_t % TICK);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("sub",   wif.o_sub,       m_sub());
        chk("sec",   wif.o_sec,       m_sec());
        chk("min",   wif.o_min,       m_min());
        chk("hour",  wif.o_hour,      disp_hour(m_hour(), mode12));
        chk("pm",    wif.o_pm,        m_hour() >= 12);
        chk("pulse", wif.o_sec_pulse, m_pulse);
    endtask

    task automatic adjust_to(input int s, input int target, input bit dir_up);
        int n = 0;
        sel  = 2'(s);
        up   = dir_up;
        down = !dir_up;
        while (m_field(s) != target && n < 30) begin
            cycle();
            n++;
        end
        up = 0; down = 0; sel = 2'd3;
        if (n >= 30) chk("adjust_bound", 1, 0);
    endtask

    // sb < 0 or ph < 0 means "any"
    task automatic wait_for(input int sb, input int ph);
        int n = 0;
        while (!((sb < 0 || m_sub() == sb) && (ph < 0 || m_phase == ph)) && n < 3000) begin
            cycle();
            n++;
        end
        if (n >= 3000) chk("wait_bound", 1, 0);
    endtask

    int hrs[6]   = '{0, 1, 11, 12, 13, 23};
    int hdisp[6] = '{12, 1, 11, 12, 1, 11};
    int hpm[6]   = '{0, 0, 0, 1, 1, 1};

    initial begin
        int n, snap_sub, snap_sec, snap_min, snap_hour;

        repeat (3) cycle();
        rst = 1'b1;
        chk("rst_sub",  wif.o_sub,  0);
        chk("rst_sec",  wif.o_sec,  0);
        chk("rst_min",  wif.o_min,  0);
        chk("rst_hour", wif.o_hour, 12);
        chk("rst_pm",   wif.o_pm,   1);
        n = 0;
        while (wif.o_sub == 0 && n < 200) begin
            cycle();
            n++;
        end
        chk("first_tick_latency", n, 100);

        clr = 1'b1; cycle(); clr = 1'b0;
        adjust_to(0, 59, 1'b0);
        adjust_to(1, 59, 1'b0);
        adjust_to(2, 23, 1'b1);
        wait_for(9, -1);
        chk("pre_hour", wif.o_hour, 23);
        chk("pre_min",  wif.o_min,  59);
        chk("pre_sec",  wif.o_sec,  59);
        wait_for(-1, DIV - 1);
        cycle();
        chk("wrap_sub",   wif.o_sub,       0);
        chk("wrap_sec",   wif.o_sec,       0);
        chk("wrap_min",   wif.o_min,       0);
        chk("wrap_hour",  wif.o_hour,      0);
        chk("wrap_pulse", wif.o_sec_pulse, 1);
        chk("wrap_pm",    wif.o_pm,        0);

        run = 1'b0;
        adjust_to(2, 5, 1'b1);
        sel = 2'd1; down = 1'b1; cycle(); down = 1'b0; sel = 2'd3;
        chk("min_borrow_min",  wif.o_min,  59);
        chk("min_borrow_hour", wif.o_hour, 5);
        adjust_to(1, 10, 1'b1);
        adjust_to(0, 59, 1'b0);
        sel = 2'd0; up = 1'b1; cycle(); up = 1'b0; sel = 2'd3;
        chk("sec_carry_sec", wif.o_sec, 0);
        chk("sec_carry_min", wif.o_min, 10);

        run = 1'b1;
        clr = 1'b1; cycle(); clr = 1'b0;
        adjust_to(0, 20, 1'b1);
        wait_for(9, DIV - 1);
        sel = 2'd0; up = 1'b1; cycle(); up = 1'b0; sel = 2'd3;
        chk("coll_sec_n",    wif.o_sec,       21);
        chk("coll_sub_n",    wif.o_sub,       9);
        chk("coll_pulse_n",  wif.o_sec_pulse, 0);
        cycle();
        chk("coll_sub_n1",   wif.o_sub,       0);
        chk("coll_sec_n1",   wif.o_sec,       22);
        chk("coll_pulse_n1", wif.o_sec_pulse, 1);

        run = 1'b0;
        mode12 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            adjust_to(2, hrs[i], 1'b1);
            chk("h12_hour", wif.o_hour, hdisp[i]);
            chk("h12_pm",   wif.o_pm,   hpm[i]);
        end
        mode12 = 1'b0;

        snap_sub = m_sub(); snap_sec = m_sec(); snap_min = m_min(); snap_hour = m_hour();
        repeat (500) cycle();
        chk("frz_sub",  wif.o_sub,  snap_sub);
        chk("frz_sec",  wif.o_sec,  snap_sec);
        chk("frz_min",  wif.o_min,  snap_min);
        chk("frz_hour", wif.o_hour, snap_hour);

        run = 1'b1;
        wait_for(-1, DIV - 1);
        sel = 2'd0; up = 1'b1; cycle(); up = 1'b0; sel = 2'd3;
        rst = 1'b0; cycle();
        chk("mid_rst_sub",  wif.o_sub,  0);
        chk("mid_rst_sec",  wif.o_sec,  0);
        chk("mid_rst_min",  wif.o_min,  0);
        chk("mid_rst_hour", wif.o_hour, 12);
        rst = 1'b1;
        repeat (50) cycle();
        chk("no_pend_after_rst", wif.o_sub, 0);

        for (int i = 0; i < 3000; i++) begin
            run    = ($urandom % 8) != 0;
            up     = ($urandom % 6) == 0;
            down   = ($urandom % 6) == 0;
            sel    = 2'($urandom % 4);
            clr    = ($urandom % 64) == 0;
            mode12 = $urandom % 2;
            rst    = ($urandom % 500) != 0;
            cycle();
        end
        rst = 1'b1; up = 1'b0; down = 1'b0; clr = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/watch_dp_gen.md
Name: watch_dp_gen

Overview:
Parametrised next-generation watch datapath. Derives a sub-second tick from the system clock and keeps a sub-second/second/minute/hour time-of-day with a same-cycle carry chain. Supports run/freeze, per-field up/down adjust, a sub-second clear, and a 12/24-hour display view. Sits between the button/mode control FSM and the FND/display formatter, replacing the fixed 100 Hz watch datapath.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency.
TICK_HZ, 100, sub-second resolution; must divide CLK_FREQ_HZ exactly; >=2.
SUB_W, 7, width of o_sub; must satisfy 2^SUB_W >= TICK_HZ.
HOUR_RST, 12, hour value after reset (0..23).
MIN_RST, 0, minute value after reset (0..59).

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
i_run  in  1  1 = time advances on ticks; 0 = frozen.
i_field_sel  in  2  adjust target: 0 = sec, 1 = min, 2 = hour, 3 = none.
i_up  in  1  one-cycle adjust-increment pulse.
i_down  in  1  one-cycle adjust-decrement pulse.
i_clr_sub  in  1  one-cycle pulse: zero sub-second and divider.
i_mode_12h  in  1  1 = 12-hour display view; 0 = 24-hour.
o_sub  out  SUB_W  sub-second count, 0..TICK_HZ-1.
o_sec  out  6  seconds, 0..59.
o_min  out  6  minutes, 0..59.
o_hour  out  5  hour for display: 0..23 (24h) or 1..12 (12h).
o_pm  out  1  1 when internal hour >= 12; valid in both modes.
o_sec_pulse  out  1  one-cycle pulse when sub-second wraps to 0.

Behaviour:
- Reset (rst=0 at an edge): divider=0, sub=0, sec=0, min=MIN_RST, internal hour=HOUR_RST, o_sec_pulse=0. Reset overrides every other input and aborts any in-progress operation, including a pending tick.
- Divider counts 0..CLK_FREQ_HZ/TICK_HZ-1 continuously, independent of i_run. A tick is an internal one-cycle strobe raised at the terminal count.
- Tick with i_run=1: sub increments. At TICK_HZ-1 it wraps to 0 and asserts o_sec_pulse in the same cycle the registers update. Carry chain is combinational: sub, sec, min and hour wraps (59->0, 59->0, 23->0) all land on the same clock edge. No one-cycle carry skew.
- Tick with i_run=0: discarded (not queued).
- Adjust: acts when exactly one of i_up/i_down is 1 and i_field_sel != 3. Changes the selected field by +/-1 with wrap (sec/min 59<->0, hour 23<->0). No carry or borrow propagates to neighbour fields. Allowed regardless of i_run.
- i_up and i_down both 1, or i_field_sel=3: no adjust.
- Adjust coinciding with a counting tick: adjust applied this cycle. Tick held in a 1-bit pending flag and applied next cycle unless another adjust is present; at most one tick pending. A pending tick is lost if i_run drops.
- i_clr_sub: sub=0 and divider=0 next cycle. Any tick or pending tick in that cycle is dropped. Higher fields unchanged. Combinable with an adjust in the same cycle.
- Display: internal hour is always 0..23.
  - 12h mode: o_hour = 12 for internal hours 0 and 12; hour-12 for 13..23; else hour.
  - Mode switch is purely combinational and never alters stored time.
- All outputs except o_hour/o_pm are direct register outputs (zero combinational path from inputs).

Optional Feature:
ALARM_EN. When defined, adds:
- Inputs: i_alarm_set (pulse; captures current internal hour/min as alarm), i_alarm_on (level).
- Output: o_alarm (one-cycle pulse when sec wraps to 0 and hour:min equals the stored alarm with i_alarm_on=1).
- Alarm register resets to 00:00.
When undefined, these ports and that logic are absent. All other behaviour is identical.

Decomposition:
- Shared package watch_pkg: field-select encodings (FLD_SEC, FLD_MIN, FLD_HOUR, FLD_NONE), SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, function for 24h->12h conversion.
- One sub-module, wdp_wrap_counter:
  - Parameters: MAX, WIDTH, RST_VAL.
  - Inputs: inc, dec.
  - Outputs: value, wrap_next (combinational carry out).
- Instantiated four times; divider stays inline.

Test Plan:
- CLK_FREQ_HZ=1000, TICK_HZ=10; hold rst=0 three cycles then release -> sub=0, sec=0, min=0, hour=12, o_pm=1; first sub increment after 100 clocks.
- Preset via adjust to 23:59:59, sub=9; next tick -> 00:00:00, sub=0, o_sec_pulse=1; all fields change on the same edge; o_pm=0.
- i_field_sel=1, i_down at min=0, hour=5 -> min=59, hour stays 5; i_up at sec=59, min=10 -> sec=0, min stays 10.
- i_up on sec coincident with a tick (sub=9, sec=20) -> cycle N: sec=21; cycle N+1: sub=0, sec=22, o_sec_pulse=1.
- i_mode_12h=1 sweep internal hours 0, 1, 11, 12, 13, 23 -> o_hour 12, 1, 11, 12, 1, 11; o_pm 0, 0, 0, 1, 1, 1.
- i_run=0 for 500 clocks -> time unchanged. Assert rst=0 mid-count with a pending tick -> reset values next edge, no pending tick applied after release.
